// File: rtl/instr_fetch_stage_if.sv
// instr_fetch_stage_if: instruction memory request/response bus
interface instr_fetch_stage_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: PC, single-outstanding imem fetch, IF/ID register with stall and redirect flush
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       reset,
  instr_fetch_stage_if.master        imem,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  input  logic                       stall,
  output logic                       ifid_valid,
  output logic [31:0]                ifid_pc,
  output logic [31:0]                ifid_instr,
  output logic [6:0]                 ifid_opcode,
  output logic [2:0]                 ifid_funct3
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
  state_t      r_state, w_state_n;
  logic [31:0] r_pc, w_pc_n, r_buf, w_buf_n;
  logic [31:0] r_ifid_pc, w_ifid_pc_n, r_ifid_instr, w_ifid_instr_n;
  logic        r_kill, w_kill_n, r_ifid_valid, w_ifid_valid_n;
  logic        w_accept, w_load;
  logic [31:0] w_load_data;
  assign imem.imem_req_valid = (r_state == S_REQ) && !reset;
  assign imem.imem_req_addr  = r_pc & 32'hFFFF_FFFC;
  assign w_accept            = imem.imem_req_valid && imem.imem_req_ready;
  assign ifid_valid          = r_ifid_valid;
  assign ifid_pc             = r_ifid_pc;
  assign ifid_instr          = r_ifid_instr;
  assign ifid_opcode         = r_ifid_instr[6:0];
  assign ifid_funct3         = r_ifid_instr[14:12];
  always_comb begin
    w_state_n      = r_state;
    w_pc_n         = r_pc;
    w_buf_n        = r_buf;
    w_kill_n       = r_kill;
    w_ifid_valid_n = r_ifid_valid && stall;
    w_ifid_pc_n    = r_ifid_pc;
    w_ifid_instr_n = r_ifid_instr;
    w_load         = 1'b0;
    w_load_data    = r_buf;
    case (r_state)
      S_REQ:  w_state_n = w_accept ? S_WAIT : S_REQ;
      S_WAIT: if (imem.imem_rsp_valid) begin
        if (r_kill) begin
          w_kill_n  = 1'b0;
          w_state_n = S_REQ;
        end else if (!r_ifid_valid || !stall) begin
          w_load      = 1'b1;
          w_load_data = imem.imem_rsp_data;
        end else begin
          w_buf_n   = imem.imem_rsp_data;
          w_state_n = S_HOLD;
        end
      end
      S_HOLD: w_load = !stall;
      default: w_state_n = S_REQ;
    endcase
    if (w_load) begin
      w_ifid_valid_n = 1'b1;
      w_ifid_pc_n    = r_pc;
      w_ifid_instr_n = w_load_data;
      w_pc_n         = r_pc + 32'd4;
      w_state_n      = S_REQ;
    end
    // a request still in flight after redirect must have its response discarded
    if (redirect_valid) begin
      w_pc_n         = redirect_pc & 32'hFFFF_FFFC;
      w_ifid_valid_n = 1'b0;
      w_ifid_instr_n = NOP_INSTR;
      w_kill_n       = (r_state == S_WAIT && !imem.imem_rsp_valid) || w_accept;
      w_state_n      = w_kill_n ? S_WAIT : S_REQ;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_kill       <= 1'b0;
      r_buf        <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= '0;
      r_ifid_instr <= NOP_INSTR;
    end else begin
      r_state      <= w_state_n;
      r_pc         <= w_pc_n;
      r_kill       <= w_kill_n;
      r_buf        <= w_buf_n;
      r_ifid_valid <= w_ifid_valid_n;
      r_ifid_pc    <= w_ifid_pc_n;
      r_ifid_instr <= w_ifid_instr_n;
    end
  end
endmodule
